// File: rtl/kmac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kmac_pkg
// Description : ALU opcodes and FSM state encoding for kernel_mac_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package kmac_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MUL  = 3'd2,
    ST_ADD  = 3'd3,
    ST_ACC  = 3'd4,
    ST_NORM = 3'd5,
    ST_NLAT = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/kmac_tap_counter.sv
`default_nettype none
// ============================================================================
// Module      : kmac_tap_counter
// Description : Tap index counter; doubles as the shared memory read address.
// Revision    : 1.0  initial release
// ============================================================================
module kmac_tap_counter #(
  parameter int TAPS   = 7,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr = cnt_q;
  assign last = (cnt_q == LAST_TAP);

endmodule
`default_nettype wire

// File: rtl/kernel_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : kernel_mac_sequencer
// Description : Sequences a shared ALU through a TAPS-point MAC and a 2^SHIFT
//               normalising divide, one output sample per start request.
//               Define KMAC_SAT_EN to saturate the accumulator and report ovf.
// Revision    : 1.0  initial release
// ============================================================================
module kernel_mac_sequencer
  import kmac_pkg::*;
#(
  parameter int TAPS   = 7,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int SHIFT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] kern_data,
  input  logic [DATA_W-1:0] pix_data,
  output logic [ACC_W-1:0]  alu_a,
  output logic [ACC_W-1:0]  alu_b,
  output logic [2:0]        alu_op,
  input  logic [ACC_W-1:0]  alu_result,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] NORM_DIV = ACC_W'(1) << SHIFT;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               last_tap;
`ifdef KMAC_SAT_EN
  logic               sat_q, sat_d;
  logic               ovf_q, ovf_d;
`endif

  kmac_tap_counter #(
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W)
  ) u_tap_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .addr (addr),
    .last (last_tap)
  );

  // Operands are combinational: memory data and the ALU result arrive in the
  // same cycle they must be forwarded.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (state_q)
      ST_MUL: begin
        alu_a  = ACC_W'(kern_data);
        alu_b  = ACC_W'(pix_data);
        alu_op = ALU_MUL;
      end
      ST_ADD: begin
        alu_a  = acc_q;
        alu_b  = alu_result;
        alu_op = ALU_ADD;
      end
      ST_NORM: begin
        alu_a  = acc_q;
        alu_b  = NORM_DIV;
        alu_op = ALU_DIV;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
`ifdef KMAC_SAT_EN
    sat_d    = sat_q;
    ovf_d    = ovf_q;
`endif
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      busy_d  = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          acc_d   = '0;
          cnt_clr = 1'b1;
          if (start && !abort) begin
            state_d = ST_RD;
            busy_d  = 1'b1;
`ifdef KMAC_SAT_EN
            sat_d   = 1'b0;
`endif
          end
        end
        ST_RD:   state_d = ST_MUL;
        ST_MUL:  state_d = ST_ADD;
        ST_ADD:  state_d = ST_ACC;
        ST_ACC: begin
          acc_d = alu_result;
`ifdef KMAC_SAT_EN
          // A wrapped sum is smaller than the old accumulator exactly on carry.
          if (alu_result < acc_q) begin
            acc_d = '1;
            sat_d = 1'b1;
          end
`endif
          if (last_tap) begin
            state_d = ST_NORM;
          end else begin
            state_d = ST_RD;
            cnt_inc = 1'b1;
          end
        end
        ST_NORM: state_d = ST_NLAT;
        ST_NLAT: begin
          state_d  = ST_IDLE;
          result_d = alu_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_clr  = 1'b1;
`ifdef KMAC_SAT_EN
          ovf_d    = sat_q;
`endif
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef KMAC_SAT_EN
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef KMAC_SAT_EN
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef KMAC_SAT_EN
  assign ovf    = ovf_q;
`else
  assign ovf    = 1'b0;
`endif

endmodule
`default_nettype wire
